// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
//
// Handshake: a request is accepted on a rising Clk edge when
// op_valid && !busy && !flush. The master must hold op/src_a/src_b stable
// with op_valid high until that edge. busy is registered and stays high
// for every cycle an accepted multi-cycle op is in flight. hi/lo are
// direct register outputs and are valid to read whenever busy is low.
// flush aborts any in-flight op at the next edge and blocks acceptance in
// the same cycle.
interface muldiv_unit_if;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output busy, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Multiplies are computed at accept and committed after MUL_LAT cycles;
// divides use a 32-step restoring divider with sign fix-up at the end.
module muldiv_unit #(
  parameter int MUL_LAT = 4
) (
  input  logic          Clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus,
  output logic [2:0]    o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_DIV_PREP = 3'd2,
    S_DIV_ITER = 3'd3,
    S_DIV_FIX  = 3'd4
  } state_t;

  localparam logic [1:0] ACC_SET = 2'd0;
  localparam logic [1:0] ACC_ADD = 2'd1;
  localparam logic [1:0] ACC_SUB = 2'd2;

  state_t      r_state;
  state_t      w_next;
  logic        r_busy;
  logic [31:0] r_hi, r_lo;
  logic [4:0]  r_cnt;
  logic [63:0] r_prod;
  logic [1:0]  r_mop;
  logic [31:0] r_a, r_b;
  logic        r_signed, r_dz, r_neg_q, r_neg_r;
  logic [31:0] r_quo, r_rem, r_dvs;

  logic        w_accept, w_op_mul, w_op_div, w_sgn_op;
  logic [63:0] w_ext_a, w_ext_b, w_prod, w_acc;
  logic [32:0] w_shift, w_trial;

  assign w_accept = bus.op_valid && !r_busy && !bus.flush;
  assign w_op_mul = (bus.op == 4'd1) || (bus.op == 4'd2) ||
                    ((bus.op >= 4'd7) && (bus.op <= 4'd11));
  assign w_op_div = (bus.op == 4'd3) || (bus.op == 4'd4);
  assign w_sgn_op = (bus.op == 4'd1) || (bus.op == 4'd7) ||
                    (bus.op == 4'd9) || (bus.op == 4'd11);

  // Sign- or zero-extend to 64 bits so one multiplier serves both flavours.
  assign w_ext_a = {{32{w_sgn_op & bus.src_a[31]}}, bus.src_a};
  assign w_ext_b = {{32{w_sgn_op & bus.src_b[31]}}, bus.src_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Accumulated result committed at the end of a multiply-class op.
  always_comb begin
    w_acc = r_prod;
    case (r_mop)
      ACC_ADD: w_acc = {r_hi, r_lo} + r_prod;
      ACC_SUB: w_acc = {r_hi, r_lo} - r_prod;
      default: w_acc = r_prod;
    endcase
  end

  // One restoring-division step: shift in next dividend bit, trial subtract.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_op_mul)      w_next = S_MUL;
        else if (w_accept && w_op_div) w_next = S_DIV_PREP;
      end
      S_MUL:      if (r_cnt == 5'd0) w_next = S_IDLE;
      S_DIV_PREP: w_next = S_DIV_ITER;
      S_DIV_ITER: if (r_cnt == 5'd0) w_next = S_DIV_FIX;
      S_DIV_FIX:  w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  // Datapath, HI/LO and registered busy.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mop    <= ACC_SET;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_op_mul) begin
              r_prod <= w_prod;
              r_cnt  <= 5'(MUL_LAT - 1);
              if ((bus.op == 4'd7) || (bus.op == 4'd8))       r_mop <= ACC_ADD;
              else if ((bus.op == 4'd9) || (bus.op == 4'd10)) r_mop <= ACC_SUB;
              else                                            r_mop <= ACC_SET;
            end
            if (w_op_div) begin
              r_a      <= bus.src_a;
              r_b      <= bus.src_b;
              r_signed <= (bus.op == 4'd3);
              r_dz     <= (bus.src_b == 32'd0);
            end
            if (bus.op == 4'd5) r_hi <= bus.src_a;
            if (bus.op == 4'd6) r_lo <= bus.src_a;
          end
        end
        S_MUL: begin
          if (r_cnt != 5'd0)    r_cnt <= r_cnt - 5'd1;
          else if (!bus.flush)  {r_hi, r_lo} <= w_acc;
        end
        S_DIV_PREP: begin
          r_quo   <= (r_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
          r_dvs   <= (r_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
          r_rem   <= '0;
          r_neg_q <= r_signed && (r_a[31] ^ r_b[31]);
          r_neg_r <= r_signed && r_a[31];
          r_cnt   <= 5'd31;
        end
        S_DIV_ITER: begin
          if (!w_trial[32]) begin
            r_rem <= w_trial[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        S_DIV_FIX: begin
          if (!bus.flush) begin
            if (r_dz) begin
              r_hi <= r_a;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_lo <= r_neg_q ? (32'd0 - r_quo) : r_quo;
              r_hi <= r_neg_r ? (32'd0 - r_rem) : r_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle compare,
// with directed vectors and literal expectations.
module tb_muldiv_unit;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 34;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  always #5 Clk = ~Clk;

  muldiv_unit_if mif();

  muldiv_unit #(.MUL_LAT(MUL_LAT)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .bus         (mif.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  int          m_left = 0;
  bit          chk_en = 1'b0;

  function automatic logic [63:0] mul_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
    longint p;
    if (op == 4'd1 || op == 4'd7 || op == 4'd9 || op == 4'd11)
      p = longint'(int'(a)) * longint'(int'(b));
    else
      p = longint'({32'd0, a}) * longint'({32'd0, b});
    if (op == 4'd7 || op == 4'd8)       return acc + 64'(p);
    else if (op == 4'd9 || op == 4'd10) return acc - 64'(p);
    else                                return 64'(p);
  endfunction

  function automatic logic [63:0] div_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 4'd3) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Model advances on the same edge as the DUT from the same sampled inputs.
  always @(posedge Clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (mif.flush) begin
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_rhi; m_lo = m_rlo;
      end
    end else if (mif.op_valid) begin
      case (mif.op)
        4'd5: m_hi = mif.src_a;
        4'd6: m_lo = mif.src_a;
        4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
          {m_rhi, m_rlo} = mul_res(mif.op, mif.src_a, mif.src_b, {m_hi, m_lo});
          m_left = MUL_LAT;
        end
        4'd3, 4'd4: begin
          {m_rhi, m_rlo} = div_res(mif.op, mif.src_a, mif.src_b);
          m_left = DIV_LAT;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", {31'd0, mif.busy}, (m_left > 0) ? 32'd1 : 32'd0);
      check("hi", mif.hi, m_hi);
      check("lo", mif.lo, m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mif.busy && n < 100) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, mif.busy}, 32'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    mif.op_valid = 1'b1;
    mif.op       = op;
    mif.src_a    = a;
    mif.src_b    = b;
    step();
    mif.op_valid = 1'b0;
    mif.src_a    = $urandom;
    mif.src_b    = $urandom;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (mif.busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int exp_len);
    int n;
    issue(op, a, b);
    busy_len(n);
    check({name, "_len"}, 32'(n), 32'(exp_len));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    mif.op_valid = 1'b0;
    mif.op       = 4'd0;
    mif.src_a    = '0;
    mif.src_b    = '0;
    mif.flush    = 1'b0;
    reset        = 1'b1;
    step(); step();
    check("rst_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_hi", mif.hi, 32'd0);
    check("rst_lo", mif.lo, 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    run("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, MUL_LAT);
    check("mult_hi", mif.hi, 32'hFFFF_FFFF);
    check("mult_lo", mif.lo, 32'hFFFF_FFFA);

    run("divu", 4'd4, 32'd100, 32'd7, DIV_LAT);
    check("divu_lo", mif.lo, 32'd14);
    check("divu_hi", mif.hi, 32'd2);

    run("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
    check("div_neg_lo", mif.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", mif.hi, 32'hFFFF_FFFF);

    run("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
    check("div_ovf_lo", mif.lo, 32'h8000_0000);
    check("div_ovf_hi", mif.hi, 32'd0);

    run("divu_z", 4'd4, 32'd5, 32'd0, DIV_LAT);
    check("divu_z_hi", mif.hi, 32'd5);
    check("divu_z_lo", mif.lo, 32'hFFFF_FFFF);

    run("div_z", 4'd3, 32'hFFFF_FFFB, 32'd0, DIV_LAT);
    run("div_7m2", 4'd3, 32'd7, 32'hFFFF_FFFE, DIV_LAT);
    check("div_7m2_lo", mif.lo, 32'hFFFF_FFFD);
    check("div_7m2_hi", mif.hi, 32'd1);
    run("divu_big", 4'd4, 32'hFFFF_FFFF, 32'h8000_0001, DIV_LAT);

    run("mthi", 4'd5, 32'd1, 32'd0, 0);
    check("mthi_hi", mif.hi, 32'd1);
    run("mtlo", 4'd6, 32'hFFFF_FFFF, 32'd0, 0);
    check("mtlo_hi_kept", mif.hi, 32'd1);
    run("maddu", 4'd8, 32'd1, 32'd1, MUL_LAT);
    check("maddu_hi", mif.hi, 32'd2);
    check("maddu_lo", mif.lo, 32'd0);

    run("mthi0", 4'd5, 32'd0, 32'd0, 0);
    run("mtlo0", 4'd6, 32'd0, 32'd0, 0);
    run("msub", 4'd9, 32'd1, 32'd1, MUL_LAT);
    check("msub_hi", mif.hi, 32'hFFFF_FFFF);
    check("msub_lo", mif.lo, 32'hFFFF_FFFF);

    run("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    check("multu_hi", mif.hi, 32'hFFFF_FFFE);
    check("multu_lo", mif.lo, 32'd1);
    run("mul", 4'd11, 32'd7, 32'hFFFF_FFFD, MUL_LAT);
    check("mul_lo", mif.lo, 32'hFFFF_FFEB);
    run("madd", 4'd7, 32'd2, 32'd3, MUL_LAT);
    check("madd_lo", mif.lo, 32'hFFFF_FFF1);
    check("madd_hi", mif.hi, 32'hFFFF_FFFF);
    run("msubu", 4'd10, 32'hFFFF_FFFF, 32'd2, MUL_LAT);

    // NOP and unused codes leave everything alone.
    run("nop", 4'd0, 32'd9, 32'd9, 0);
    run("op13", 4'd13, 32'd9, 32'd9, 0);

    // Flush on the 10th busy cycle of a divide.
    run("mthi_f", 4'd5, 32'd1234, 32'd0, 0);
    run("mtlo_f", 4'd6, 32'd5678, 32'd0, 0);
    issue(4'd3, 32'd50, 32'd3);
    repeat (9) step();
    mif.flush = 1'b1;
    step();
    mif.flush = 1'b0;
    check("flush_busy", {31'd0, mif.busy}, 32'd0);
    check("flush_hi", mif.hi, 32'd1234);
    check("flush_lo", mif.lo, 32'd5678);
    run("mult_after_flush", 4'd1, 32'd3, 32'd4, MUL_LAT);
    check("maf_lo", mif.lo, 32'd12);
    check("maf_hi", mif.hi, 32'd0);

    // Flush on the completing cycle cancels the write.
    issue(4'd1, 32'd9, 32'd9);
    repeat (3) step();
    mif.flush = 1'b1;
    step();
    mif.flush = 1'b0;
    check("flush_end_busy", {31'd0, mif.busy}, 32'd0);
    check("flush_end_lo", mif.lo, 32'd12);

    // op_valid together with flush is not accepted.
    mif.op_valid = 1'b1; mif.op = 4'd1; mif.src_a = 32'd2; mif.src_b = 32'd2;
    mif.flush = 1'b1;
    step();
    mif.op_valid = 1'b0; mif.flush = 1'b0;
    check("flush_acc_busy", {31'd0, mif.busy}, 32'd0);

    // Request held while busy with a different op waits for busy to fall.
    issue(4'd4, 32'd1000, 32'd10);
    mif.op_valid = 1'b1; mif.op = 4'd2; mif.src_a = 32'd6; mif.src_b = 32'd7;
    n = 0;
    while (mif.busy && n < 100) begin
      step();
      n++;
    end
    check("held_div_lo", mif.lo, 32'd100);
    step();
    mif.op_valid = 1'b0;
    check("held_busy", {31'd0, mif.busy}, 32'd1);
    busy_len(n);
    check("held_len", 32'(n), 32'(MUL_LAT));
    check("held_lo", mif.lo, 32'd42);

    // Reset in the middle of a multiply.
    issue(4'd1, 32'd5, 32'd5);
    step();
    reset = 1'b1;
    step();
    check("rst_mid_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_mid_hi", mif.hi, 32'd0);
    check("rst_mid_lo", mif.lo, 32'd0);
    reset = 1'b0;
    run("mult_after_rst", 4'd1, 32'd6, 32'd6, MUL_LAT);
    check("mar_lo", mif.lo, 32'd36);

    step(); step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop if the sequence itself never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
